wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Write-back stage directly downstream of the memory stage.
- Consumes the memory stage's write-back pulse, result and micro-op. Drives the single 64-bit register-file write port and retires instructions.
- 128-bit "wide" results (RDX:RAX-style pairs) are written over two cycles. During the second cycle the stage back-pressures the memory stage with wb_blocked.
- Keeps a retired-instruction counter and a sticky overrun error flag.

Parameters:
- NREGS, 16, number of architectural GPRs; register index width is $clog2(NREGS).
- HI_REG, 2, register index that receives result[127:64] on a wide write (RDX).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  one-cycle write-back pulse from the memory stage (its mem_wb).
- uop  in  micro_op_t  micro-op accompanying the pulse. Uses oprd1.t, oprd1.r, next_rip.
- wide  in  1  result carries a valid upper half; sampled with enable.
- result  in  128  result from the memory stage (its mem_result).
- wb_blocked  out  1  registered; high while the second half of a wide write is pending.
- rf_wren  out  1  register-file write enable.
- rf_waddr  out  $clog2(NREGS)  register-file write index.
- rf_wdata  out  64  register-file write data.
- retire_valid  out  1  one-cycle pulse per retired micro-op.
- retire_rip  out  64  next_rip of the retiring micro-op.
- retire_count  out  64  total micro-ops retired since reset.
- wb_overrun  out  1  sticky error: enable arrived while wb_blocked was high.

Behaviour:
- Single clock and synchronous active-high reset, as decided. All outputs are registered.
- Reset values: all outputs 0 (including retire_count and wb_overrun). State is WB_IDLE; the captured hi-half register is cleared.
- Reset takes priority over everything. A pending hi write is dropped and is not retired.
- States: WB_IDLE, WB_HI.
- WB_IDLE, enable=0:
  - rf_wren=0, retire_valid=0 next cycle.
- WB_IDLE, enable=1, sampled at edge N; the following take effect in cycle N+1:
  - Register destination (uop.oprd1.t == `OPRD_T_REG): rf_wren=1, rf_waddr=uop.oprd1.r, rf_wdata=result[63:0].
  - Any other destination (MEM, STACK, none): rf_wren=0. Memory writes have already completed upstream.
  - wide=1: capture result[127:64] and next_rip. Go to WB_HI and set wb_blocked=1. No retire this cycle.
  - wide=0: retire_valid=1, retire_rip=uop.next_rip, retire_count+=1. Stay in WB_IDLE.
- WB_HI, active in cycle N+1; the following take effect in cycle N+2:
  - rf_wren=1, rf_waddr=HI_REG, rf_wdata=captured hi half.
  - retire_valid=1, retire_rip=captured rip, retire_count+=1.
  - wb_blocked=0, return to WB_IDLE.
  - The hi write happens even when the destination is not a register (the implicit-RDX case).
- Latency: 1 cycle for narrow results, 2 cycles for wide. Throughput is 1 per cycle narrow, 1 per 2 cycles wide.
- Overrun: enable=1 while in WB_HI means the upstream stage ignored back-pressure.
  - The new op is dropped.
  - wb_overrun latches to 1 until reset.
  - The pending hi write completes normally.
- Both writes of a wide op going to the same index (oprd1.r == HI_REG): both occur in order, so the hi value wins.
- retire_count wraps modulo 2^64 silently.
- retire_valid and rf_wren are pulses. They deassert the cycle after their event unless a new event occurs back-to-back.

Optional Feature:
- Macro: WB_FWD_EN.
- When defined, adds combinational outputs:
  - fwd_valid (1)
  - fwd_reg ($clog2(NREGS))
  - fwd_data (64)
- These mirror the write that will be presented on the next cycle, so the decode/register-read stage can bypass one cycle early:
  - In WB_IDLE, driven from enable/uop/result. fwd_valid = enable && register destination.
  - In WB_HI, driven from HI_REG and the captured hi half, with fwd_valid=1.
- When undefined, these ports do not exist and behaviour is otherwise identical.

Decomposition:
- The shared micro-op header already provides micro_op_t and the `OPRD_T_* constants. Reuse them; do not redefine them.
- New package wb_pkg holds:
  - the wb_state_t enum (WB_IDLE, WB_HI);
  - the default HI_REG constant.
- No sub-module is needed; the two-state FSM plus counter is compact.
- Optional: retire_counter as a trivial sub-module, only if it is shared with performance counters.

Test Plan:
- Reset: reset high for 2 cycles, mid-traffic -> all outputs 0, wb_overrun=0, retire_count=0. A pending WB_HI is discarded.
- Narrow reg write: enable=1, oprd1.t=REG, r=5, result=0x..._1234, wide=0 -> next cycle: rf_wren=1, waddr=5, wdata=0x1234, retire_valid=1, retire_count=1.
- Wide write: r=0, result={64'hAAAA, 64'hBBBB}, wide=1 ->
  - cycle+1: waddr=0, wdata=0xBBBB, wb_blocked=1, no retire.
  - cycle+2: waddr=2, wdata=0xAAAA, retire_valid=1, wb_blocked=0.
- Non-reg destination: oprd1.t=MEM, wide=0 -> rf_wren=0, retire_valid=1 with retire_rip=uop.next_rip.
- Back-to-back narrow: enable high 4 consecutive cycles, regs 1..4 -> 4 consecutive writes in order, retire_count=4.
- Overrun: wide op, then enable=1 during wb_blocked -> second op is never written, wb_overrun=1 and stays set, hi write still lands on reg 2.

Source files
------------

// File: rtl/micro_op_pkg.sv
// Shared micro-op header: operand-type constants and the micro_op_t carried down the pipe.
// Consumed by every stage from decode onward; wb_stage only looks at oprd1 and next_rip.
`ifndef MICRO_OP_DEFS
`define MICRO_OP_DEFS
`define OPRD_T_NONE  2'd0
`define OPRD_T_REG   2'd1
`define OPRD_T_MEM   2'd2
`define OPRD_T_STACK 2'd3
`endif

package micro_op_pkg;

    typedef struct packed {
        logic [1:0] t;
        logic [3:0] r;
    } oprd_t;

    typedef struct packed {
        oprd_t       oprd1;
        logic [63:0] next_rip;
    } micro_op_t;

endpackage

// File: rtl/wb_pkg.sv
// Write-back stage package: FSM state encoding, default high-half register index,
// and a destination-decode helper shared by the datapath and the forwarding path.
package wb_pkg;

    typedef enum logic [0:0] {
        WB_IDLE = 1'b0,
        WB_HI   = 1'b1
    } wb_state_t;

    // RDX receives the upper half of RDX:RAX-style results
    localparam int WB_HI_REG_DEFAULT = 2;

    function automatic logic wb_is_reg_dst(input logic [1:0] t);
        return (t == `OPRD_T_REG);
    endfunction

endpackage

// File: rtl/wb_stage.sv
// Write-back stage: drives the single 64-bit register-file write port, splits 128-bit
// results over two cycles with back-pressure, retires micro-ops. Optional macro WB_FWD_EN.
module wb_stage
    import micro_op_pkg::*;
    import wb_pkg::*;
#(
    parameter int NREGS  = 16,
    parameter int HI_REG = WB_HI_REG_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  micro_op_t                uop,
    input  logic                     wide,
    input  logic [127:0]             result,
    output logic                     wb_blocked,
    output logic                     rf_wren,
    output logic [$clog2(NREGS)-1:0] rf_waddr,
    output logic [63:0]              rf_wdata,
    output logic                     retire_valid,
    output logic [63:0]              retire_rip,
    output logic [63:0]              retire_count,
`ifdef WB_FWD_EN
    output logic                     fwd_valid,
    output logic [$clog2(NREGS)-1:0] fwd_reg,
    output logic [63:0]              fwd_data,
`endif
    output logic                     wb_overrun
);

    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] HI_IDX = AW'(HI_REG);

    wb_state_t     r_state;
    logic          r_blocked;
    logic          r_rf_wren;
    logic [AW-1:0] r_rf_waddr;
    logic [63:0]   r_rf_wdata;
    logic          r_retire_valid;
    logic [63:0]   r_retire_rip;
    logic [63:0]   r_retire_count;
    logic          r_overrun;
    logic [63:0]   r_hi_data;
    logic [63:0]   r_hi_rip;

    wb_state_t     w_state_next;
    logic          w_blocked;
    logic          w_rf_wren;
    logic [AW-1:0] w_rf_waddr;
    logic [63:0]   w_rf_wdata;
    logic          w_retire_valid;
    logic [63:0]   w_retire_rip;
    logic [63:0]   w_retire_count;
    logic          w_overrun;
    logic [63:0]   w_hi_data;
    logic [63:0]   w_hi_rip;
    logic          w_is_reg;
    logic [AW-1:0] w_dst_idx;

    assign w_is_reg  = wb_is_reg_dst(uop.oprd1.t);
    assign w_dst_idx = AW'(uop.oprd1.r);

    // Next-state and next-output decode; address/data/rip hold when not written
    always_comb begin
        w_state_next   = r_state;
        w_blocked      = 1'b0;
        w_rf_wren      = 1'b0;
        w_rf_waddr     = r_rf_waddr;
        w_rf_wdata     = r_rf_wdata;
        w_retire_valid = 1'b0;
        w_retire_rip   = r_retire_rip;
        w_retire_count = r_retire_count;
        w_overrun      = r_overrun;
        w_hi_data      = r_hi_data;
        w_hi_rip       = r_hi_rip;
        case (r_state)
            WB_IDLE: begin
                if (enable) begin
                    if (w_is_reg) begin
                        w_rf_wren  = 1'b1;
                        w_rf_waddr = w_dst_idx;
                        w_rf_wdata = result[63:0];
                    end else begin
                        w_rf_wren  = 1'b0;
                    end
                    if (wide) begin
                        // Retirement waits for the upper half to land
                        w_hi_data    = result[127:64];
                        w_hi_rip     = uop.next_rip;
                        w_blocked    = 1'b1;
                        w_state_next = WB_HI;
                    end else begin
                        w_retire_valid = 1'b1;
                        w_retire_rip   = uop.next_rip;
                        w_retire_count = r_retire_count + 64'd1;
                    end
                end else begin
                    w_state_next = WB_IDLE;
                end
            end
            WB_HI: begin
                // Upper half always goes to HI_REG, even for non-register destinations
                w_rf_wren      = 1'b1;
                w_rf_waddr     = HI_IDX;
                w_rf_wdata     = r_hi_data;
                w_retire_valid = 1'b1;
                w_retire_rip   = r_hi_rip;
                w_retire_count = r_retire_count + 64'd1;
                w_state_next   = WB_IDLE;
                if (enable) begin
                    w_overrun = 1'b1;
                end else begin
                    w_overrun = r_overrun;
                end
            end
            default: begin
                w_state_next = WB_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= WB_IDLE;
            r_blocked      <= 1'b0;
            r_rf_wren      <= 1'b0;
            r_rf_waddr     <= '0;
            r_rf_wdata     <= 64'd0;
            r_retire_valid <= 1'b0;
            r_retire_rip   <= 64'd0;
            r_retire_count <= 64'd0;
            r_overrun      <= 1'b0;
            r_hi_data      <= 64'd0;
            r_hi_rip       <= 64'd0;
        end else begin
            r_state        <= w_state_next;
            r_blocked      <= w_blocked;
            r_rf_wren      <= w_rf_wren;
            r_rf_waddr     <= w_rf_waddr;
            r_rf_wdata     <= w_rf_wdata;
            r_retire_valid <= w_retire_valid;
            r_retire_rip   <= w_retire_rip;
            r_retire_count <= w_retire_count;
            r_overrun      <= w_overrun;
            r_hi_data      <= w_hi_data;
            r_hi_rip       <= w_hi_rip;
        end
    end

    assign wb_blocked   = r_blocked;
    assign rf_wren      = r_rf_wren;
    assign rf_waddr     = r_rf_waddr;
    assign rf_wdata     = r_rf_wdata;
    assign retire_valid = r_retire_valid;
    assign retire_rip   = r_retire_rip;
    assign retire_count = r_retire_count;
    assign wb_overrun   = r_overrun;

`ifdef WB_FWD_EN
    // Early view of the write that the register file will see next cycle
    always_comb begin
        fwd_valid = 1'b0;
        fwd_reg   = '0;
        fwd_data  = 64'd0;
        case (r_state)
            WB_IDLE: begin
                fwd_valid = enable && w_is_reg;
                fwd_reg   = w_dst_idx;
                fwd_data  = result[63:0];
            end
            WB_HI: begin
                fwd_valid = 1'b1;
                fwd_reg   = HI_IDX;
                fwd_data  = r_hi_data;
            end
            default: begin
                fwd_valid = 1'b0;
            end
        endcase
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed-vector bench for wb_stage: narrow, wide, non-register, back-to-back,
// overrun and mid-traffic reset cases with hand-computed expectations.
module tb_wb_stage;
    import micro_op_pkg::*;

    logic          clk;
    logic          reset;
    logic          enable;
    micro_op_t     uop;
    logic          wide;
    logic [127:0]  result;
    logic          wb_blocked;
    logic          rf_wren;
    logic [3:0]    rf_waddr;
    logic [63:0]   rf_wdata;
    logic          retire_valid;
    logic [63:0]   retire_rip;
    logic [63:0]   retire_count;
    logic          wb_overrun;
`ifdef WB_FWD_EN
    logic          fwd_valid;
    logic [3:0]    fwd_reg;
    logic [63:0]   fwd_data;
`endif

    int n_vec = 0;
    int n_err = 0;

    wb_stage #(.NREGS(16), .HI_REG(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .uop          (uop),
        .wide         (wide),
        .result       (result),
        .wb_blocked   (wb_blocked),
        .rf_wren      (rf_wren),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .retire_valid (retire_valid),
        .retire_rip   (retire_rip),
        .retire_count (retire_count),
`ifdef WB_FWD_EN
        .fwd_valid    (fwd_valid),
        .fwd_reg      (fwd_reg),
        .fwd_data     (fwd_data),
`endif
        .wb_overrun   (wb_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [1:0] t, input logic [3:0] r,
                         input logic [63:0] rip, input logic wd, input logic [127:0] res);
        enable         = en;
        uop.oprd1.t    = t;
        uop.oprd1.r    = r;
        uop.next_rip   = rip;
        wide           = wd;
        result         = res;
    endtask

    task automatic idle();
        drive(1'b0, `OPRD_T_NONE, 4'd0, 64'd0, 1'b0, 128'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wren"},  {63'd0, rf_wren},      64'd0);
        chk({tag, "_waddr"}, {60'd0, rf_waddr},     64'd0);
        chk({tag, "_wdata"}, rf_wdata,              64'd0);
        chk({tag, "_rv"},    {63'd0, retire_valid}, 64'd0);
        chk({tag, "_rip"},   retire_rip,            64'd0);
        chk({tag, "_cnt"},   retire_count,          64'd0);
        chk({tag, "_blk"},   {63'd0, wb_blocked},   64'd0);
        chk({tag, "_ovr"},   {63'd0, wb_overrun},   64'd0);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        step();
        step();
        chk_all_zero("rst");

        // Narrow register write to r5
        reset = 1'b0;
        drive(1'b1, `OPRD_T_REG, 4'd5, 64'h1000, 1'b0, {64'h0, 64'hDEAD_0000_0000_1234});
`ifdef WB_FWD_EN
        #1;
        chk("fwd_nar_v", {63'd0, fwd_valid}, 64'd1);
        chk("fwd_nar_r", {60'd0, fwd_reg}, 64'd5);
        chk("fwd_nar_d", fwd_data, 64'hDEAD_0000_0000_1234);
`endif
        step();
        chk("nar_wren",  {63'd0, rf_wren}, 64'd1);
        chk("nar_waddr", {60'd0, rf_waddr}, 64'd5);
        chk("nar_wdata", rf_wdata, 64'hDEAD_0000_0000_1234);
        chk("nar_rv",    {63'd0, retire_valid}, 64'd1);
        chk("nar_rip",   retire_rip, 64'h1000);
        chk("nar_cnt",   retire_count, 64'd1);
        chk("nar_blk",   {63'd0, wb_blocked}, 64'd0);
        idle();
        step();
        chk("nar_wren_off", {63'd0, rf_wren}, 64'd0);
        chk("nar_rv_off",   {63'd0, retire_valid}, 64'd0);
        chk("nar_cnt_hold", retire_count, 64'd1);

        // Wide write to r0: lo then hi on RDX
        drive(1'b1, `OPRD_T_REG, 4'd0, 64'h2000, 1'b1, {64'hAAAA, 64'hBBBB});
        step();
        idle();
        chk("wlo_wren",  {63'd0, rf_wren}, 64'd1);
        chk("wlo_waddr", {60'd0, rf_waddr}, 64'd0);
        chk("wlo_wdata", rf_wdata, 64'hBBBB);
        chk("wlo_blk",   {63'd0, wb_blocked}, 64'd1);
        chk("wlo_rv",    {63'd0, retire_valid}, 64'd0);
        chk("wlo_cnt",   retire_count, 64'd1);
`ifdef WB_FWD_EN
        chk("fwd_hi_v", {63'd0, fwd_valid}, 64'd1);
        chk("fwd_hi_r", {60'd0, fwd_reg}, 64'd2);
        chk("fwd_hi_d", fwd_data, 64'hAAAA);
`endif
        step();
        chk("whi_wren",  {63'd0, rf_wren}, 64'd1);
        chk("whi_waddr", {60'd0, rf_waddr}, 64'd2);
        chk("whi_wdata", rf_wdata, 64'hAAAA);
        chk("whi_rv",    {63'd0, retire_valid}, 64'd1);
        chk("whi_rip",   retire_rip, 64'h2000);
        chk("whi_blk",   {63'd0, wb_blocked}, 64'd0);
        chk("whi_cnt",   retire_count, 64'd2);
        step();
        chk("wide_wren_off", {63'd0, rf_wren}, 64'd0);

        // Memory destination: retires without a register write
        drive(1'b1, `OPRD_T_MEM, 4'd7, 64'h3000, 1'b0, {64'h0, 64'h5555});
        step();
        idle();
        chk("mem_wren", {63'd0, rf_wren}, 64'd0);
        chk("mem_rv",   {63'd0, retire_valid}, 64'd1);
        chk("mem_rip",  retire_rip, 64'h3000);
        chk("mem_cnt",  retire_count, 64'd3);

        // Four back-to-back narrow writes to r1..r4
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, `OPRD_T_REG, 4'(i), 64'h4000 + 64'(i), 1'b0, {64'h0, 64'h11 * 64'(i)});
            step();
            chk("b2b_wren",  {63'd0, rf_wren}, 64'd1);
            chk("b2b_waddr", {60'd0, rf_waddr}, 64'(i));
            chk("b2b_wdata", rf_wdata, 64'h11 * 64'(i));
            chk("b2b_rv",    {63'd0, retire_valid}, 64'd1);
            chk("b2b_rip",   retire_rip, 64'h4000 + 64'(i));
            chk("b2b_cnt",   retire_count, 64'd3 + 64'(i));
        end
        idle();
        step();
        chk("b2b_cnt_end", retire_count, 64'd7);
        chk("b2b_rv_off",  {63'd0, retire_valid}, 64'd0);

        // Wide op targeting RDX itself: hi value lands second
        drive(1'b1, `OPRD_T_REG, 4'd2, 64'h2222, 1'b1, {64'hCCCC, 64'hDDDD});
        step();
        idle();
        chk("same_lo_waddr", {60'd0, rf_waddr}, 64'd2);
        chk("same_lo_wdata", rf_wdata, 64'hDDDD);
        step();
        chk("same_hi_waddr", {60'd0, rf_waddr}, 64'd2);
        chk("same_hi_wdata", rf_wdata, 64'hCCCC);
        chk("same_cnt",      retire_count, 64'd8);

        // Overrun: enable during wb_blocked is dropped and flagged
        drive(1'b1, `OPRD_T_REG, 4'd3, 64'h5000, 1'b1, {64'h1111, 64'h2222});
        step();
        chk("ovr_blk",    {63'd0, wb_blocked}, 64'd1);
        chk("ovr_pre",    {63'd0, wb_overrun}, 64'd0);
        drive(1'b1, `OPRD_T_REG, 4'd9, 64'h6000, 1'b0, {64'h0, 64'h9999});
        step();
        idle();
        chk("ovr_flag",   {63'd0, wb_overrun}, 64'd1);
        chk("ovr_waddr",  {60'd0, rf_waddr}, 64'd2);
        chk("ovr_wdata",  rf_wdata, 64'h1111);
        chk("ovr_rip",    retire_rip, 64'h5000);
        chk("ovr_cnt",    retire_count, 64'd9);
        step();
        chk("ovr_drop_wren", {63'd0, rf_wren}, 64'd0);
        chk("ovr_drop_rv",   {63'd0, retire_valid}, 64'd0);
        chk("ovr_drop_cnt",  retire_count, 64'd9);
        step();
        chk("ovr_sticky",    {63'd0, wb_overrun}, 64'd1);

        // Implicit-RDX: wide op with no register destination
        drive(1'b1, `OPRD_T_NONE, 4'd6, 64'h7000, 1'b1, {64'h7777, 64'h8888});
        step();
        idle();
        chk("irdx_lo_wren", {63'd0, rf_wren}, 64'd0);
        chk("irdx_blk",     {63'd0, wb_blocked}, 64'd1);
        step();
        chk("irdx_hi_wren",  {63'd0, rf_wren}, 64'd1);
        chk("irdx_hi_waddr", {60'd0, rf_waddr}, 64'd2);
        chk("irdx_hi_wdata", rf_wdata, 64'h7777);
        chk("irdx_cnt",      retire_count, 64'd10);

        // Reset while a hi write is pending
        drive(1'b1, `OPRD_T_REG, 4'd4, 64'h8000, 1'b1, {64'hEEEE, 64'hFFFF});
        step();
        chk("mrst_blk_pre", {63'd0, wb_blocked}, 64'd1);
        reset = 1'b1;
        idle();
        step();
        chk_all_zero("mrst1");
        step();
        chk_all_zero("mrst2");
        reset = 1'b0;
        step();
        chk("mrst_wren", {63'd0, rf_wren}, 64'd0);
        chk("mrst_rv",   {63'd0, retire_valid}, 64'd0);
        chk("mrst_cnt",  retire_count, 64'd0);

        // Counting restarts from zero
        drive(1'b1, `OPRD_T_REG, 4'd5, 64'h9000, 1'b0, {64'h0, 64'h1234});
        step();
        idle();
        chk("post_waddr", {60'd0, rf_waddr}, 64'd5);
        chk("post_cnt",   retire_count, 64'd1);
        chk("post_ovr",   {63'd0, wb_overrun}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
